key_schedule_bank: RTL and testbench

- Parametrised successor to the two-stage evolution/selection key schedule.
- Expands a 2*KEY_W master key (K1||K2) into NUM_KEYS round keys with a Feistel-style recurrence: ITER_PER_PAIR iterations per key pair, one iteration per clock.
- Stores every round key in an internal bank and serves random-access reads in encrypt or decrypt order.
- Sits between key load and the round datapath. The nonlinear round function F is external and shared with the cipher core, reached through a combinational port pair.

---
 rtl/ks_pkg.sv | 22 ++
 rtl/key_schedule_bank_rf.sv | 49 ++++
 rtl/key_schedule_bank.sv | 150 +++++++++++++++
 tb/tb_key_schedule_bank.sv | 452 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ks_pkg.sv
// Shared types and defaults for the round-key expansion bank.
// Build with KS_ZEROIZE_EN to add the synchronous zeroize port.
package ks_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    DONE   = 2'd2
  } ks_state_e;

  localparam int KS_KEY_W    = 128;
  localparam int KS_NUM_KEYS = 10;
  localparam int KS_ITER_PP  = 8;

  function automatic int unsigned rev_idx(
    input int unsigned idx,
    input int unsigned n
  );
    return n - 1 - idx;
  endfunction

endpackage

// File: rtl/key_schedule_bank_rf.sv
// Round-key register file: pair-wide write port,
// registered read port, async reset and sync clear.
module key_bank_rf
  import ks_pkg::*;
#(
  parameter int KEY_W    = KS_KEY_W,
  parameter int NUM_KEYS = KS_NUM_KEYS,
  parameter int IDX_W    = $clog2(NUM_KEYS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_pair,
  input  logic [KEY_W-1:0] wr_lo,
  input  logic [KEY_W-1:0] wr_hi,
  input  logic             rd_en,
  input  logic [IDX_W-1:0] rd_addr,
  output logic [KEY_W-1:0] rd_key
);

  logic [KEY_W-1:0] mem [NUM_KEYS];
  logic [IDX_W-1:0] lo_idx;
  logic [IDX_W-1:0] hi_idx;

  assign lo_idx = {wr_pair[IDX_W-2:0], 1'b0};
  assign hi_idx = {wr_pair[IDX_W-2:0], 1'b1};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_KEYS; i++)
        mem[i] <= '0;
      rd_key <= '0;
    end else if (clr) begin
      for (int i = 0; i < NUM_KEYS; i++)
        mem[i] <= '0;
      rd_key <= '0;
    end else begin
      // read sees the pre-write contents
      if (rd_en)
        rd_key <= mem[rd_addr];
      if (wr_en) begin
        mem[lo_idx] <= wr_lo;
        mem[hi_idx] <= wr_hi;
      end
    end
  end

endmodule

// File: rtl/key_schedule_bank.sv
// Feistel key expansion into a random-access round-key bank.
// Optional KS_ZEROIZE_EN adds a synchronous zeroize input.
module key_schedule_bank
  import ks_pkg::*;
#(
  parameter int KEY_W         = KS_KEY_W,
  parameter int NUM_KEYS      = KS_NUM_KEYS,
  parameter int ITER_PER_PAIR = KS_ITER_PP,
  parameter int IDX_W         = $clog2(NUM_KEYS),
  parameter int CIDX_W        =
    $clog2((NUM_KEYS/2-1)*ITER_PER_PAIR)
) (
  input  logic               clk,
  input  logic               reset,
`ifdef KS_ZEROIZE_EN
  input  logic               zeroize,
`endif
  input  logic               start,
  input  logic [2*KEY_W-1:0] master_key,
  input  logic               encrypt,
  output logic [KEY_W-1:0]   f_data,
  output logic [CIDX_W-1:0]  f_cidx,
  input  logic [KEY_W-1:0]   f_result,
  output logic               busy,
  output logic               ready,
  input  logic               rd_en,
  input  logic [IDX_W-1:0]   rd_idx,
  output logic [KEY_W-1:0]   rd_key,
  output logic               rd_valid,
  output logic               rd_err
);

  localparam int LAST_PAIR = NUM_KEYS/2 - 1;
  localparam int ITER_W =
    ITER_PER_PAIR > 1 ? $clog2(ITER_PER_PAIR) : 1;

  ks_state_e         state_q, state_d;
  logic [KEY_W-1:0]  a_q, b_q, a_next;
  logic [IDX_W-1:0]  pair_q;
  logic [ITER_W-1:0] iter_q;
  logic              zap, load, step;
  logic              last_iter, last_pair;
  logic              rd_ok;
  logic [IDX_W-1:0]  rd_addr;

`ifdef KS_ZEROIZE_EN
  assign zap = zeroize;
`else
  assign zap = 1'b0;
`endif

  assign busy      = state_q == EXPAND;
  assign ready     = state_q == DONE;
  assign load      = start && !busy && !zap;
  assign step      = busy && !zap;
  assign last_iter = 32'(iter_q) == ITER_PER_PAIR - 1;
  assign last_pair = 32'(pair_q) == LAST_PAIR;
  assign a_next    = f_result ^ b_q;

  assign f_data = a_q;
  assign f_cidx = busy
    ? CIDX_W'((32'(pair_q) - 1) * ITER_PER_PAIR
              + 32'(iter_q))
    : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE:
        if (start) state_d = EXPAND;
      EXPAND:
        if (last_iter && last_pair) state_d = DONE;
      default:
        state_d = IDLE;
    endcase
    if (zap) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q    <= '0;
      b_q    <= '0;
      pair_q <= '0;
      iter_q <= '0;
    end else if (zap) begin
      a_q    <= '0;
      b_q    <= '0;
      pair_q <= '0;
      iter_q <= '0;
    end else if (load) begin
      a_q    <= master_key[2*KEY_W-1:KEY_W];
      b_q    <= master_key[KEY_W-1:0];
      pair_q <= IDX_W'(1);
      iter_q <= '0;
    end else if (step) begin
      a_q <= a_next;
      b_q <= a_q;
      if (last_iter) begin
        iter_q <= '0;
        pair_q <= pair_q + 1'b1;
      end else begin
        iter_q <= iter_q + 1'b1;
      end
    end
  end

  assign rd_ok = rd_en && ready
    && (32'(rd_idx) < NUM_KEYS);
  assign rd_addr = encrypt ? rd_idx
    : IDX_W'(rev_idx(32'(rd_idx), NUM_KEYS));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_valid <= 1'b0;
      rd_err   <= 1'b0;
    end else if (zap) begin
      rd_valid <= 1'b0;
      rd_err   <= 1'b0;
    end else begin
      rd_valid <= rd_ok;
      rd_err   <= rd_en && !rd_ok;
    end
  end

  key_bank_rf #(
    .KEY_W    (KEY_W),
    .NUM_KEYS (NUM_KEYS),
    .IDX_W    (IDX_W)
  ) u_rf (
    .clk     (clk),
    .reset   (reset),
    .clr     (zap),
    .wr_en   (load || (step && last_iter)),
    .wr_pair (load ? '0 : pair_q),
    .wr_lo   (load ? master_key[2*KEY_W-1:KEY_W]
                   : a_next),
    .wr_hi   (load ? master_key[KEY_W-1:0] : a_q),
    .rd_en   (rd_ok),
    .rd_addr (rd_addr),
    .rd_key  (rd_key)
  );

endmodule

// File: tb/tb_key_schedule_bank.sv
// Randomized bench for key_schedule_bank against a
// plain-arithmetic model of the key expansion.
module tb_key_schedule_bank;

  localparam int NK  = 10;
  localparam int IPP = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [255:0] master_key;
  logic         encrypt;
  logic [127:0] f_data;
  logic [4:0]   f_cidx;
  logic [127:0] f_result;
  logic         busy;
  logic         ready;
  logic         rd_en;
  logic [3:0]   rd_idx;
  logic [127:0] rd_key;
  logic         rd_valid;
  logic         rd_err;
`ifdef KS_ZEROIZE_EN
  logic         zeroize = 1'b0;
`endif

  int errors = 0;
  int checks = 0;
  logic [127:0] ref_keys [NK];

  always #5 clk = ~clk;

  assign f_result = f_data ^ {16{8'(f_cidx)}};

  key_schedule_bank dut (
    .clk        (clk),
    .reset      (reset),
`ifdef KS_ZEROIZE_EN
    .zeroize    (zeroize),
`endif
    .start      (start),
    .master_key (master_key),
    .encrypt    (encrypt),
    .f_data     (f_data),
    .f_cidx     (f_cidx),
    .f_result   (f_result),
    .busy       (busy),
    .ready      (ready),
    .rd_en      (rd_en),
    .rd_idx     (rd_idx),
    .rd_key     (rd_key),
    .rd_valid   (rd_valid),
    .rd_err     (rd_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_expand(input logic [255:0] mk);
    logic [127:0] a, b, na;
    a = mk[255:128];
    b = mk[127:0];
    ref_keys[0] = a;
    ref_keys[1] = b;
    for (int p = 1; p < NK/2; p++) begin
      for (int i = 0; i < IPP; i++) begin
        na = a ^ {16{8'((p-1)*IPP + i)}} ^ b;
        b  = a;
        a  = na;
      end
      ref_keys[2*p]   = a;
      ref_keys[2*p+1] = b;
    end
  endtask

  function automatic logic [255:0] rand_key();
    return {$urandom, $urandom, $urandom, $urandom,
            $urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic do_read(input int idx, input logic enc);
    rd_en   = 1'b1;
    rd_idx  = idx[3:0];
    encrypt = enc;
    step();
    rd_en = 1'b0;
  endtask

  task automatic run_expand(input logic [255:0] mk,
                            output int cycles);
    master_key = mk;
    start = 1'b1;
    step();
    start  = 1'b0;
    cycles = 0;
    while (busy && cycles < 200) begin
      step();
      cycles++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    start = 1'b0;
    rd_en = 1'b0;
    encrypt = 1'b1;
    rd_idx = '0;
    master_key = '0;
    #12;
    checks++;
    if ({busy, ready, rd_valid, rd_err} !== 4'b0 ||
        rd_key !== '0 || f_data !== '0 ||
        f_cidx !== '0) begin
      errors++;
      $display("FAIL reset: busy=%b ready=%b v=%b e=%b key=%h fd=%h fc=%0d, all 0 required",
               busy, ready, rd_valid, rd_err, rd_key,
               f_data, f_cidx);
    end
    @(negedge clk);
    reset = 1'b1;
    step();
    checks++;
    if (busy !== 1'b0 || ready !== 1'b0) begin
      errors++;
      $display("FAIL idle: busy=%b ready=%b, 0/0 required",
               busy, ready);
    end
  endtask

  task automatic test_zero_key();
    int cycles;
    model_expand('0);
    master_key = '0;
    start = 1'b1;
    step();
    start  = 1'b0;
    cycles = 0;
    while (busy && cycles < 200) begin
      checks++;
      if (f_cidx !== 5'(cycles)) begin
        errors++;
        $display("FAIL cidx: got %0d, %0d required",
                 f_cidx, cycles);
      end
      step();
      cycles++;
    end
    checks++;
    if (cycles !== 32 || ready !== 1'b1) begin
      errors++;
      $display("FAIL zero_latency: busy %0d cycles ready=%b, 32/1 required",
               cycles, ready);
    end
    for (int k = 0; k < NK; k++) begin
      do_read(k, 1'b1);
      checks++;
      if (rd_valid !== 1'b1 || rd_key !== ref_keys[k]) begin
        errors++;
        $display("FAIL zero_key[%0d]: v=%b got %h, %h required",
                 k, rd_valid, rd_key, ref_keys[k]);
      end
    end
  endtask

  task automatic test_known_key();
    int cycles;
    logic [127:0] k1, k2;
    k1 = 128'h00112233445566778899aabbccddeeff;
    k2 = 128'hfedcba9876543210fedcba9876540123;
    model_expand({k1, k2});
    run_expand({k1, k2}, cycles);
    checks++;
    if (cycles !== 32) begin
      errors++;
      $display("FAIL known_latency: %0d, 32 required",
               cycles);
    end
    do_read(0, 1'b1);
    checks++;
    if (rd_valid !== 1'b1 || rd_key !== k1) begin
      errors++;
      $display("FAIL enc_idx0: got %h, %h required",
               rd_key, k1);
    end
    do_read(9, 1'b0);
    checks++;
    if (rd_valid !== 1'b1 || rd_key !== k1) begin
      errors++;
      $display("FAIL dec_idx9: got %h, %h required",
               rd_key, k1);
    end
    do_read(8, 1'b0);
    checks++;
    if (rd_valid !== 1'b1 || rd_key !== k2) begin
      errors++;
      $display("FAIL dec_idx8: got %h, %h required",
               rd_key, k2);
    end
    do_read(3, 1'b0);
    checks++;
    if (rd_key !== ref_keys[6]) begin
      errors++;
      $display("FAIL dec_idx3: got %h, %h required",
               rd_key, ref_keys[6]);
    end
  endtask

  task automatic test_random();
    int cycles, idx;
    logic enc;
    logic [255:0] mk;
    logic [127:0] exp;
    for (int t = 0; t < 3; t++) begin
      mk = rand_key();
      model_expand(mk);
      run_expand(mk, cycles);
      checks++;
      if (cycles !== 32) begin
        errors++;
        $display("FAIL rand_latency: %0d, 32 required",
                 cycles);
      end
      for (int r = 0; r < 12; r++) begin
        idx = $urandom_range(0, NK-1);
        enc = 1'($urandom % 2);
        exp = enc ? ref_keys[idx] : ref_keys[NK-1-idx];
        do_read(idx, enc);
        checks++;
        if (rd_valid !== 1'b1 || rd_key !== exp) begin
          errors++;
          $display("FAIL rand_read idx=%0d enc=%b: got %h, %h required",
                   idx, enc, rd_key, exp);
        end
        if ($urandom % 2 == 1) step();
      end
    end
  endtask

  task automatic test_errors();
    int cycles;
    logic [127:0] prev;
    logic [255:0] mk;
    prev = rd_key;
    do_read(10, 1'b1);
    checks++;
    if (rd_err !== 1'b1 || rd_valid !== 1'b0 ||
        rd_key !== prev) begin
      errors++;
      $display("FAIL idx10: err=%b v=%b key=%h, 1/0/%h required",
               rd_err, rd_valid, rd_key, prev);
    end
    step();
    checks++;
    if (rd_err !== 1'b0) begin
      errors++;
      $display("FAIL err_pulse: err=%b, 0 required",
               rd_err);
    end
    mk = rand_key();
    model_expand(mk);
    master_key = mk;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (3) step();
    do_read(2, 1'b1);
    checks++;
    if (rd_err !== 1'b1 || rd_valid !== 1'b0 ||
        rd_key !== prev) begin
      errors++;
      $display("FAIL busy_read: err=%b v=%b key=%h, 1/0/%h required",
               rd_err, rd_valid, rd_key, prev);
    end
    cycles = 4;
    while (busy && cycles < 200) begin
      step();
      cycles++;
    end
    checks++;
    if (cycles !== 32 || ready !== 1'b1) begin
      errors++;
      $display("FAIL err_latency: %0d ready=%b, 32/1 required",
               cycles, ready);
    end
  endtask

  task automatic test_start_ignored();
    int cycles;
    logic [255:0] mka, mkb;
    mka = rand_key();
    mkb = rand_key();
    model_expand(mka);
    master_key = mka;
    start = 1'b1;
    step();
    start  = 1'b0;
    cycles = 0;
    while (busy && cycles < 200) begin
      start = cycles == 5;
      if (cycles == 5) master_key = mkb;
      step();
      cycles++;
    end
    start = 1'b0;
    checks++;
    if (cycles !== 32 || ready !== 1'b1) begin
      errors++;
      $display("FAIL ignore_latency: %0d ready=%b, 32/1 required",
               cycles, ready);
    end
    for (int k = 0; k < NK; k++) begin
      do_read(k, 1'b1);
      checks++;
      if (rd_key !== ref_keys[k]) begin
        errors++;
        $display("FAIL ignore_key[%0d]: got %h, %h required",
                 k, rd_key, ref_keys[k]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int cycles;
    logic [255:0] mk;
    mk = rand_key();
    master_key = mk;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (17) step();
    reset = 1'b0;
    #1;
    checks++;
    if ({busy, ready, rd_valid, rd_err} !== 4'b0 ||
        rd_key !== '0 || f_data !== '0 ||
        f_cidx !== '0) begin
      errors++;
      $display("FAIL mid_reset: busy=%b ready=%b v=%b e=%b key=%h fd=%h fc=%0d, all 0 required",
               busy, ready, rd_valid, rd_err, rd_key,
               f_data, f_cidx);
    end
    step();
    reset = 1'b1;
    step();
    mk = rand_key();
    model_expand(mk);
    run_expand(mk, cycles);
    checks++;
    if (cycles !== 32 || ready !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_latency: %0d, 32 required",
               cycles);
    end
    for (int k = 0; k < NK; k++) begin
      do_read(k, 1'b0);
      checks++;
      if (rd_key !== ref_keys[NK-1-k]) begin
        errors++;
        $display("FAIL post_reset_key[%0d]: got %h, %h required",
                 k, rd_key, ref_keys[NK-1-k]);
      end
    end
  endtask

  task automatic test_start_with_read();
    int cycles;
    logic [255:0] mk;
    logic [127:0] old4;
    old4 = ref_keys[4];
    mk = rand_key();
    master_key = mk;
    start   = 1'b1;
    rd_en   = 1'b1;
    rd_idx  = 4'd4;
    encrypt = 1'b1;
    step();
    start = 1'b0;
    rd_en = 1'b0;
    checks++;
    if (rd_valid !== 1'b1 || rd_key !== old4 ||
        busy !== 1'b1 || ready !== 1'b0) begin
      errors++;
      $display("FAIL start_read: v=%b busy=%b ready=%b key=%h, 1/1/0/%h required",
               rd_valid, busy, ready, rd_key, old4);
    end
    model_expand(mk);
    cycles = 0;
    while (busy && cycles < 200) begin
      step();
      cycles++;
    end
    do_read(4, 1'b1);
    checks++;
    if (cycles !== 32 || rd_key !== ref_keys[4]) begin
      errors++;
      $display("FAIL rekey: %0d cycles key=%h, 32/%h required",
               cycles, rd_key, ref_keys[4]);
    end
  endtask

`ifdef KS_ZEROIZE_EN
  task automatic test_zeroize();
    zeroize = 1'b1;
    start   = 1'b1;
    master_key = rand_key();
    step();
    zeroize = 1'b0;
    start   = 1'b0;
    checks++;
    if (ready !== 1'b0 || busy !== 1'b0 ||
        rd_key !== '0 || f_data !== '0) begin
      errors++;
      $display("FAIL zeroize: ready=%b busy=%b key=%h fd=%h, all 0 required",
               ready, busy, rd_key, f_data);
    end
    do_read(1, 1'b1);
    checks++;
    if (rd_err !== 1'b1 || rd_valid !== 1'b0 ||
        rd_key !== '0) begin
      errors++;
      $display("FAIL zeroize_read: err=%b v=%b key=%h, 1/0/0 required",
               rd_err, rd_valid, rd_key);
    end
  endtask
`endif

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_zero_key();
    test_known_key();
    test_random();
    test_errors();
    test_start_ignored();
    test_reset_mid();
    test_start_with_read();
`ifdef KS_ZEROIZE_EN
    test_zeroize();
`endif
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
